// File: rtl/instruction_register_pkg.sv
// Shared ISA definitions: instruction field positions
// and opcode constants used by decode and control.
package instruction_register_pkg;

   localparam int INST_W = 32;

   // Field bit positions inside the instruction word.
   // R/I/J/S fields overlap on purpose, so several
   // ranges cover the same bits.
   localparam int OP_HI   = 31;
   localparam int OP_LO   = 26;
   localparam int RD_HI   = 25;
   localparam int RD_LO   = 22;
   localparam int RS1_HI  = 21;
   localparam int RS1_LO  = 18;
   localparam int RS2_HI  = 17;
   localparam int RS2_LO  = 14;
   localparam int IMM_HI  = 17;
   localparam int IMM_LO  = 2;
   localparam int MODE_HI = 1;
   localparam int MODE_LO = 0;
   localparam int JOFF_HI = 25;
   localparam int JOFF_LO = 0;

   // Field widths derived from the positions above.
   localparam int OP_W   = OP_HI - OP_LO + 1;
   localparam int REG_W  = RD_HI - RD_LO + 1;
   localparam int IMM_W  = IMM_HI - IMM_LO + 1;
   localparam int MODE_W = MODE_HI - MODE_LO + 1;
   localparam int JOFF_W = JOFF_HI - JOFF_LO + 1;

   // Opcodes recognised by decode/control downstream.
   // This register does not check them.
   typedef enum logic [OP_W-1:0] {
      OP_AND   = 6'd0,
      OP_ADD   = 6'd1,
      OP_SUB   = 6'd2,
      OP_ANDI  = 6'd3,
      OP_JMP   = 6'd12,
      OP_STORE = 6'd15
   } opcode_e;

endpackage

// File: rtl/instruction_register.sv
// Instruction register: latches the fetched word each
// cycle and exposes every decode field as a raw slice.
module instruction_register
   import instruction_register_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [INST_W-1:0] inst,
   output logic [OP_W-1:0]   op_code,
   output logic [REG_W-1:0]  inst_rd,
   output logic [REG_W-1:0]  inst_rs1,
   output logic [REG_W-1:0]  inst_rs2,
   output logic [IMM_W-1:0]  imm_16,
   output logic [JOFF_W-1:0] jump_offset,
   output logic [MODE_W-1:0] Mode
);

   logic [INST_W-1:0] ir;

   // Load the fetched word every edge; reset wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         ir <= '0;
      end else begin
         ir <= inst;
      end
   end

   // Fields come from the register only, so they hold
   // steady while inst moves between edges.
   assign op_code     = ir[OP_HI:OP_LO];
   assign inst_rd     = ir[RD_HI:RD_LO];
   assign inst_rs1    = ir[RS1_HI:RS1_LO];
   assign inst_rs2    = ir[RS2_HI:RS2_LO];
   assign imm_16      = ir[IMM_HI:IMM_LO];
   assign jump_offset = ir[JOFF_HI:JOFF_LO];
   assign Mode        = ir[MODE_HI:MODE_LO];

endmodule

// File: tb/tb_instruction_register.sv
// Bench for instruction_register: scoreboard of
// expected IR words, field checks after each edge.
module tb_instruction_register;

   logic        clk;
   logic        rst;
   logic [31:0] inst;
   logic [5:0]  op_code;
   logic [3:0]  inst_rd;
   logic [3:0]  inst_rs1;
   logic [3:0]  inst_rs2;
   logic [15:0] imm_16;
   logic [25:0] jump_offset;
   logic [1:0]  Mode;

   int vectors = 0;
   int errors  = 0;
   logic [31:0] sb[$];

   instruction_register dut (
      .clk         (clk),
      .rst         (rst),
      .inst        (inst),
      .op_code     (op_code),
      .inst_rd     (inst_rd),
      .inst_rs1    (inst_rs1),
      .inst_rs2    (inst_rs2),
      .imm_16      (imm_16),
      .jump_offset (jump_offset),
      .Mode        (Mode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Compare every field against a word popped from
   // the scoreboard, sliced with literal positions.
   task automatic compare_fields(input string tag);
      logic [31:0] e;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      check({tag, "_op"},   {26'd0, op_code},    {26'd0, e[31:26]});
      check({tag, "_rd"},   {28'd0, inst_rd},    {28'd0, e[25:22]});
      check({tag, "_rs1"},  {28'd0, inst_rs1},   {28'd0, e[21:18]});
      check({tag, "_rs2"},  {28'd0, inst_rs2},   {28'd0, e[17:14]});
      check({tag, "_imm"},  {16'd0, imm_16},     {16'd0, e[17:2]});
      check({tag, "_joff"}, {6'd0, jump_offset}, {6'd0, e[25:0]});
      check({tag, "_mode"}, {30'd0, Mode},       {30'd0, e[1:0]});
   endtask

   task automatic apply(input string tag,
                        input logic r,
                        input logic [31:0] v);
      @(negedge clk);
      rst  = r;
      inst = v;
      sb.push_back(r ? 32'h0 : v);
      @(posedge clk);
      #1;
      compare_fields(tag);
   endtask

   initial begin
      rst  = 1'b1;
      inst = 32'h0;

      // reset with a nonzero word present: reset wins
      apply("reset", 1'b1, 32'hDEAD_BEEF);

      apply("rtype", 1'b0, 32'h09A0_4033);
      check("r_op",  {26'd0, op_code},  32'h02);
      check("r_rd",  {28'd0, inst_rd},  32'h6);
      check("r_rs1", {28'd0, inst_rs1}, 32'h8);
      check("r_rs2", {28'd0, inst_rs2}, 32'h1);

      apply("itype", 1'b0, 32'h0C31_0033);
      check("i_op",   {26'd0, op_code},  32'h03);
      check("i_rd",   {28'd0, inst_rd},  32'h0);
      check("i_rs1",  {28'd0, inst_rs1}, 32'hC);
      check("i_imm",  {16'd0, imm_16},   32'h400C);
      check("i_mode", {30'd0, Mode},     32'h3);

      apply("jtype", 1'b0, 32'h300D_01B3);
      check("j_op",   {26'd0, op_code},    32'h0C);
      check("j_joff", {6'd0, jump_offset}, 32'h00D_01B3);

      apply("stype", 1'b0, 32'h3C80_003F);
      check("s_op",   {26'd0, op_code}, 32'h0F);
      check("s_rd",   {28'd0, inst_rd}, 32'h2);
      check("s_mode", {30'd0, Mode},    32'h3);

      // change inst mid-cycle: outputs must hold
      @(negedge clk);
      inst = 32'hFFFF_FFFF;
      sb.push_back(32'hFFFF_FFFF);
      #2;
      check("hold_op",   {26'd0, op_code},    32'h0F);
      check("hold_joff", {6'd0, jump_offset}, 32'h080_003F);
      @(posedge clk);
      #1;
      compare_fields("ones");
      check("ones_imm", {16'd0, imm_16},   32'hFFFF);
      check("ones_rs2", {28'd0, inst_rs2}, 32'hF);

      // mid-stream reset, then release
      apply("pre_rst", 1'b0, 32'h09A0_4033);
      apply("mid_rst", 1'b1, 32'hFFFF_FFFF);
      check("mid_rst_joff", {6'd0, jump_offset}, 32'h0);
      apply("post_rst", 1'b0, 32'hFFFF_FFFF);
      check("post_rst_op", {26'd0, op_code}, 32'h3F);

      // random words, including unknown opcodes
      for (int i = 0; i < 12; i++) begin
         apply("rand", 1'b0, $urandom);
      end
      apply("unk_op", 1'b0, 32'hFC00_0001);

      check("sb_drained", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end

endmodule

// File: doc/instruction_register.md
INSTRUCTION_REGISTER -- requirements
Module: instruction_register

Interface
REQ-001 The interface SHALL use one clock and a synchronous, active-high reset.
REQ-002 Port `clk`: input, 1 bit; rising-edge clock.
REQ-003 Port `rst`: input, 1 bit; synchronous, active-high reset.
REQ-004 Port `inst`: input, 32 bits; instruction word from instruction memory.
REQ-005 Port `op_code`: output, 6 bits; opcode field.
REQ-006 Port `inst_rd`: output, 4 bits; destination register field.
REQ-007 Port `inst_rs1`: output, 4 bits; source register 1 field.
REQ-008 Port `inst_rs2`: output, 4 bits; source register 2 field.
REQ-009 Port `imm_16`: output, 16 bits; raw immediate for I-type, not extended.
REQ-010 Port `jump_offset`: output, 26 bits; raw J-type offset, not extended.
REQ-011 Port `Mode`: output, 2 bits; I-type mode field.

Function
REQ-012 The block SHALL hold a 32-bit instruction register IR.
- Each rising `clk` with `rst`=0 loads IR <= `inst`.
- There is no load enable.
REQ-013 All outputs SHALL be combinational slices of IR, never of `inst` directly.
- An instruction appears on the outputs after the first rising edge following its presentation: one-cycle latency.
- Outputs then stay stable until the next edge.
REQ-014 The field map SHALL be:
- `op_code` = IR[31:26]
- `inst_rd` = IR[25:22]
- `inst_rs1` = IR[21:18]
- `inst_rs2` = IR[17:14]
- `imm_16` = IR[17:2]
- `Mode` = IR[1:0]
- `jump_offset` = IR[25:0]
REQ-015 Every field SHALL be driven for every instruction, regardless of opcode or type (R/I/J/S).
- Fields overlap by design.
- Consumers select the relevant fields using `op_code`.
REQ-016 The block SHALL perform no sign extension, opcode validation or illegal-instruction detection.
- Unknown opcodes are held and sliced like any other opcode.
REQ-017 If `inst` changes between clock edges, the outputs SHALL NOT change; only the value sampled at the edge matters.

Reset
REQ-018 When `rst`=1 at a rising edge, the block SHALL clear IR to 32'h0.
- All outputs then read 0.
- The behaviour is the same when reset arrives in mid-stream.
REQ-019 `rst` SHALL take priority over loading `inst` on the same edge.
REQ-020 The first rising edge with `rst`=0 SHALL load `inst` normally.

Structure
REQ-021 The field bit-position constants SHALL live in the shared ISA package, together with the opcode constants used by decode/control.
- Opcode constants: AND=0, ADD=1, SUB=2, ANDI=3, JMP=12, 15 (S-type).
REQ-022 The block SHALL be a single module with no sub-modules: one 32-bit register plus field assigns.

Verification
REQ-023 R-type scenario: `inst`=32'h09A04033, one edge.
- `op_code`=000010
- `inst_rd`=0110
- `inst_rs1`=1000
- `inst_rs2`=0001
REQ-024 I-type scenario: `inst`=32'h0C310033, one edge.
- `op_code`=000011
- `inst_rd`=0000
- `inst_rs1`=1100
- `imm_16`=16'h400C
- `Mode`=11
REQ-025 J-type scenario: `inst`=32'h300D01B3, one edge.
- `op_code`=001100
- `jump_offset`=26'h00D01B3
REQ-026 S-type scenario: `inst`=32'h3C80003F, one edge.
- `op_code`=001111
- `inst_rd`=0010
- `Mode`=11
REQ-027 Latency/hold scenario: change `inst` to 32'hFFFFFFFF midway between edges.
- Outputs keep their previous values until the next rising edge.
- After that edge, all fields read all-ones.
REQ-028 Reset scenario: load 32'h09A04033, then assert `rst` for one edge while `inst`=32'hFFFFFFFF.
- All outputs read 0.
- Deasserting `rst` loads 32'hFFFFFFFF on the next edge.
